// File: rtl/calc_op_sequencer.sv
// Sign-magnitude calculator: one add/sub/mul/div per start, sequenced IDLE->EXEC->CHECK->DONE.
// Mul is radix-2 shift-add and div is restoring division, each iterating WIDTH cycles.
module calc_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    input  logic             a_sign,
    input  logic             b_sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_sign,
    output logic             err_ovf,
    output logic             err_div0
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [2*WIDTH-1:0] MAX_FULL = (2*WIDTH)'(MAX_VAL);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, CHECK, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_mag_r, b_mag_r;
    logic               a_sign_r, b_sign_r;
    logic [2*WIDTH-1:0] prod_r;
    logic               sign_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] mag_full;
    logic               div0_req;

    // Sign-magnitude add; returns {sign, WIDTH+1 bit magnitude}.
    function automatic logic [WIDTH+1:0] sm_add(
        input logic [WIDTH-1:0] am, input logic as_,
        input logic [WIDTH-1:0] bm, input logic bs_);
        logic [WIDTH:0] mag;
        logic           sgn;
        if (as_ == bs_) begin
            mag = {1'b0, am} + {1'b0, bm};
            sgn = as_;
        end else if (am >= bm) begin
            mag = {1'b0, am} - {1'b0, bm};
            sgn = as_;
        end else begin
            mag = {1'b0, bm} - {1'b0, am};
            sgn = bs_;
        end
        return {sgn, mag};
    endfunction

    // One shift-add step: multiplier sits in the low half and shifts out as the product grows.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0] upper;
        upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
        return {upper, p[WIDTH-1:1]};
    endfunction

    // One restoring step: remainder in the high half, dividend/quotient in the low half.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] dvsr);
        logic [WIDTH:0] part;
        logic [WIDTH:0] trial;
        part  = p[2*WIDTH-1:WIDTH-1];
        trial = part - {1'b0, dvsr};
        if (!trial[WIDTH])
            return {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        else
            return {p[2*WIDTH-2:0], 1'b0};
    endfunction

    assign div0_req = (op == OP_DIV) && (b_mag == '0);
    assign mag_full = (op_r == OP_DIV) ? {{WIDTH{1'b0}}, prod_r[WIDTH-1:0]} : prod_r;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = div0_req ? DONE : EXEC;
            EXEC:  if (!op_r[1] || cnt_r == '0) state_nxt = CHECK;
            CHECK: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= '0;
            a_mag_r     <= '0;
            b_mag_r     <= '0;
            a_sign_r    <= 1'b0;
            b_sign_r    <= 1'b0;
            prod_r      <= '0;
            sign_r      <= 1'b0;
            cnt_r       <= '0;
            result      <= '0;
            result_sign <= 1'b0;
            err_ovf     <= 1'b0;
            err_div0    <= 1'b0;
        end else begin
            case (state)
                // Accept: latch operands, clear outputs, preload the iteration register.
                IDLE: if (start) begin
                    op_r        <= op;
                    a_mag_r     <= a_mag;
                    b_mag_r     <= b_mag;
                    a_sign_r    <= a_sign;
                    b_sign_r    <= b_sign;
                    sign_r      <= a_sign ^ b_sign;
                    cnt_r       <= CNT_W'(WIDTH - 1);
                    result      <= '0;
                    result_sign <= 1'b0;
                    err_ovf     <= 1'b0;
                    err_div0    <= div0_req;
                    case (op)
                        OP_MUL:  prod_r <= {{WIDTH{1'b0}}, b_mag};
                        OP_DIV:  prod_r <= {{WIDTH{1'b0}}, a_mag};
                        default: prod_r <= '0;
                    endcase
                end
                EXEC: begin
                    case (op_r)
                        OP_MUL: prod_r <= mul_step(prod_r, a_mag_r);
                        OP_DIV: prod_r <= div_step(prod_r, b_mag_r);
                        default: begin
                            logic [WIDTH+1:0] sum;
                            sum    = sm_add(a_mag_r, a_sign_r, b_mag_r, b_sign_r ^ (op_r != OP_ADD));
                            sign_r <= sum[WIDTH+1];
                            prod_r <= {{(WIDTH-1){1'b0}}, sum[WIDTH:0]};
                        end
                    endcase
                    if (op_r[1] && cnt_r != '0) cnt_r <= cnt_r - 1'b1;
                end
                // Range check against the display limit; zero is always positive.
                CHECK: begin
                    if (mag_full > MAX_FULL) begin
                        err_ovf     <= 1'b1;
                        result      <= '0;
                        result_sign <= 1'b0;
                    end else begin
                        result      <= mag_full[WIDTH-1:0];
                        result_sign <= sign_r && (mag_full != '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed corner cases plus random ops against an integer model.
module tb_calc_op_sequencer;

    localparam int WIDTH   = 16;
    localparam int MAX_VAL = 9999;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_sign, b_sign;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic             result_sign, err_ovf, err_div0;

    int passed = 0;
    int total  = 0;

    calc_op_sequencer #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_mag(a_mag), .b_mag(b_mag), .a_sign(a_sign), .b_sign(b_sign),
        .busy(busy), .done(done), .result(result), .result_sign(result_sign),
        .err_ovf(err_ovf), .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Model works on signed integers; the sequencer's algorithms play no part here.
    task automatic model(input logic [1:0] o, input int a, input bit as_, input int b, input bit bs_,
                         output int mag, output bit sgn, output bit ovf, output bit dz, output int lat);
        longint sa, sb, r;
        sa  = as_ ? -longint'(a) : longint'(a);
        sb  = bs_ ? -longint'(b) : longint'(b);
        dz  = 0;
        ovf = 0;
        case (o)
            2'd0: r = sa + sb;
            2'd1: r = sa - sb;
            2'd2: r = sa * sb;
            default: if (b == 0) begin dz = 1; r = 0; end else r = sa / sb;
        endcase
        lat = dz ? 1 : (o[1] ? WIDTH + 2 : 3);
        mag = int'(r < 0 ? -r : r);
        if (mag > MAX_VAL) begin ovf = 1; mag = 0; end
        sgn = (r < 0) && !ovf;
    endtask

    task automatic drive_start(input logic [1:0] o, input int a, input bit as_, input int b, input bit bs_);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        a_mag  = WIDTH'(a);
        b_mag  = WIDTH'(b);
        a_sign = as_;
        b_sign = bs_;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one operation, measuring latency in cycles after the accepting edge.
    task automatic run_op(input string tag, input logic [1:0] o, input int a, input bit as_,
                          input int b, input bit bs_);
        int mag, lat, k;
        bit sgn, ovf, dz;
        model(o, a, as_, b, bs_, mag, sgn, ovf, dz, lat);
        drive_start(o, a, as_, b, bs_);
        check({tag, "_busy"}, busy, 1);
        k = 1;
        while (!done && k <= 40) begin
            @(posedge clk);
            #1 k++;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_res"}, result, mag);
        check({tag, "_sign"}, result_sign, sgn);
        check({tag, "_ovf"}, err_ovf, ovf);
        check({tag, "_div0"}, err_div0, dz);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {busy, done}, 2'b00);
        check({tag, "_hold"}, {result_sign, err_ovf, err_div0, result}, {sgn, ovf, dz, WIDTH'(mag)});
    endtask

    initial begin
        int dones, held;
        logic [1:0] ro;
        int ra, rb;

        rst = 1'b1; start = 1'b0; op = '0; a_mag = '0; b_mag = '0; a_sign = 1'b0; b_sign = 1'b0;
        #1;
        check("reset_outs", {busy, done, result_sign, err_ovf, err_div0, result}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_op("add_25_m40", 2'd0, 25, 0, 40, 1);
        run_op("mul_99_101", 2'd2, 99, 0, 101, 0);
        run_op("mul_ovf", 2'd2, 100, 0, 100, 0);
        run_op("div_1000_m7", 2'd3, 1000, 0, 7, 1);
        run_op("div0", 2'd3, 5, 0, 0, 0);
        run_op("sub_7_7", 2'd1, 7, 0, 7, 0);
        run_op("mul_m3_0", 2'd2, 3, 1, 0, 0);
        run_op("add_wide", 2'd0, 65535, 0, 65535, 0);
        run_op("sub_neg", 2'd1, 5, 1, 9994, 0);
        run_op("div_neg_neg", 2'd3, 65535, 1, 7, 1);

        // Start pulsed mid-multiply must be ignored.
        drive_start(2'd2, 99, 0, 101, 0);
        repeat (2) @(posedge clk);
        drive_start(2'd0, 1, 0, 1, 0);
        dones = 0;
        held  = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) begin dones++; held = result; end
        end
        check("busy_done_count", dones, 1);
        check("busy_result", held, 9999);

        // Reset in cycle N+8 of a multiply aborts it silently.
        drive_start(2'd2, 50, 0, 60, 1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_outs", {busy, done, result_sign, err_ovf, err_div0, result}, '0);
        check("rst_mid_state", dut.state, 0);
        @(negedge clk) rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("rst_no_done", dones, 0);
        rst = 1'b1;
        #1 @(negedge clk) rst = 1'b0;
        run_op("add_after_rst", 2'd0, 25, 0, 40, 1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case (ro)
                2'd2:    begin ra = $urandom_range(0, 250);   rb = $urandom_range(0, 250); end
                2'd3:    begin ra = $urandom_range(0, 65535); rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300); end
                default: begin ra = $urandom_range(0, 12000); rb = $urandom_range(0, 12000); end
            endcase
            run_op("rand", ro, ra, 1'($urandom), rb, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
